// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: opcodes used by the control FSM decoder, the NOP
// word that fills the instruction register at reset, and fetch state encoding.
package riscv_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_WAIT  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC/OldPC, issues one valid/ready read per FETCH
// request, captures the word into the instruction register, applies PC+4 or redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_start,
  input  logic            pc_update,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            instr_valid,
  output logic            fetch_busy,
  output logic            fetch_fault
);

  fetch_state_e    state, state_nxt;
  logic            redirect_pending;
  logic [XLEN-1:0] redirect_pc;
  logic            aligned;
  logic            rsp_ok;

  assign aligned = (pc[1:0] == 2'b00);
  assign rsp_ok  = imem_rsp_valid & ~imem_rsp_err;

  always_ff @(posedge clk) begin
    if (!reset) state <= FS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE: begin
        // a redirect in the same cycle wins; the fetch request is dropped
        if (!pc_update && fetch_start) state_nxt = aligned ? FS_REQ : FS_FAULT;
      end
      FS_REQ:   if (imem_req_ready) state_nxt = FS_WAIT;
      FS_WAIT:  if (imem_rsp_valid) state_nxt = imem_rsp_err ? FS_FAULT : FS_IDLE;
      FS_FAULT: if (pc_update) state_nxt = FS_IDLE;
      default:  state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc               <= RESET_PC;
      old_pc           <= RESET_PC;
      instr            <= INSTR_NOP;
      instr_valid      <= 1'b0;
      redirect_pending <= 1'b0;
      redirect_pc      <= RESET_PC;
    end else begin
      case (state)
        FS_IDLE: begin
          if (pc_update) pc <= pc_next;
          else if (fetch_start && aligned) begin
            old_pc      <= pc;
            instr_valid <= 1'b0;
          end
        end
        FS_REQ: begin
          if (pc_update) begin
            redirect_pc      <= pc_next;
            redirect_pending <= 1'b1;
          end
        end
        FS_WAIT: begin
          if (rsp_ok) begin
            // a redirect arriving with the response is the latest one
            instr            <= imem_rsp_data;
            instr_valid      <= 1'b1;
            redirect_pending <= 1'b0;
            if (pc_update)             pc <= pc_next;
            else if (redirect_pending) pc <= redirect_pc;
            else                       pc <= pc + XLEN'(4);
          end else if (pc_update) begin
            redirect_pc      <= pc_next;
            redirect_pending <= 1'b1;
          end
        end
        FS_FAULT: begin
          if (pc_update) begin
            pc               <= pc_next;
            redirect_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc;
  assign opcode         = instr[6:0];
  assign fetch_busy     = (state == FS_REQ) | (state == FS_WAIT);
  assign fetch_fault    = (state == FS_FAULT);

endmodule
